// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: command encodings, sequencer states and
// elaboration-time helpers for mode-register fields and cycle counts.
package sdram_pkg;

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_PRE  = 4'b0010;
    localparam logic [3:0] CMD_AREF = 4'b0001;
    localparam logic [3:0] CMD_MRS  = 4'b0000;
    localparam logic [3:0] CMD_ACT  = 4'b0011;
    localparam logic [3:0] CMD_RD   = 4'b0101;
    localparam logic [3:0] CMD_WR   = 4'b0100;

    typedef enum logic [2:0] {
        ST_PWR,
        ST_TRP,
        ST_TRFC,
        ST_TMRD,
        ST_IDLE,
        ST_RTRP,
        ST_RTRFC
    } aref_state_e;

    // Mode-register burst-length field; 0 selects full page.
    function automatic logic [2:0] bl_code(input int bl);
        case (bl)
            1:       return 3'b000;
            2:       return 3'b001;
            4:       return 3'b010;
            8:       return 3'b011;
            default: return 3'b111;
        endcase
    endfunction

    function automatic bit bl_legal(input int bl);
        return (bl == 0) || (bl == 1) || (bl == 2) || (bl == 4) || (bl == 8);
    endfunction

    function automatic int us_to_cyc(input int us, input int clk_ns);
        return (us * 1000) / clk_ns;
    endfunction

endpackage

// File: rtl/sdram_aref_timer.sv
// Free-running refresh interval timer. Raises a refresh request on every
// interval expiry and latches a sticky miss flag if the previous request
// was still pending when the next interval expired.
module sdram_aref_timer #(
    parameter int T_REFI_CYC = 390
) (
    input  logic sclk,
    input  logic s_rst_n,
    input  logic enable,
    input  logic req_clr,
    output logic aref_req,
    output logic aref_miss
);

    localparam int              TMR_W  = $clog2(T_REFI_CYC + 1);
    localparam logic [TMR_W-1:0] RELOAD = TMR_W'(T_REFI_CYC - 1);

    logic [TMR_W-1:0] cnt;
    logic             expire;

    // The counter never restarts on a grant, so the long-run refresh rate is exact.
    assign expire = enable && (cnt == '0);

    // Interval down-counter, request set/clear and sticky miss.
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            cnt       <= RELOAD;
            aref_req  <= 1'b0;
            aref_miss <= 1'b0;
        end else begin
            if (!enable || expire) begin
                cnt <= RELOAD;
            end else begin
                cnt <= cnt - 1'b1;
            end
            // A new expiry wins over a same-cycle clear: the fresh interval needs its own refresh.
            if (expire) begin
                aref_req <= 1'b1;
            end else if (req_clr) begin
                aref_req <= 1'b0;
            end
            if (expire && aref_req && !req_clr) begin
                aref_miss <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/sdram_init_aref.sv
// SDRAM power-up initialisation and periodic auto-refresh sequencer.
//
// state    | meaning
// ---------+------------------------------------------------------------
// PWR      | power-up wait; PRECHARGE-all issued on leaving
// TRP      | init tRP wait after PRECHARGE; AREF issued on leaving
// TRFC     | init tRFC wait; next AREF or MRS issued on leaving
// TMRD     | tMRD wait after MRS; init_done set on leaving
// IDLE     | normal operation; PRECHARGE-all issued on granted request
// RTRP     | refresh tRP wait; AREF issued on leaving
// RTRFC    | refresh tRFC wait; aref_done pulsed on leaving
//
// Commands are registered together with the state transition, so a command
// appears on the bus in the same cycle the FSM enters the following wait state.
module sdram_init_aref
    import sdram_pkg::*;
#(
    parameter int CLK_PERIOD_NS = 20,
    parameter int T_POWERUP_US  = 200,
    parameter int T_RP_CYC      = 2,
    parameter int T_RFC_CYC     = 7,
    parameter int T_MRD_CYC     = 2,
    parameter int INIT_AREF_NUM = 8,
    parameter int T_REFI_CYC    = 390,
    parameter int CAS_LAT       = 3,
    parameter int BURST_LEN     = 4,
    parameter int ADDR_W        = 13,
    parameter int BANK_W        = 2
) (
    input  logic              sclk,
    input  logic              s_rst_n,
    output logic              sdram_cke,
    output logic [3:0]        sdram_cmd,
    output logic [ADDR_W-1:0] sdram_addr,
    output logic [BANK_W-1:0] sdram_bank,
    output logic              init_done,
    output logic              aref_req,
    input  logic              aref_en,
    output logic              aref_done,
    output logic              aref_miss
);

    localparam int T_POWERUP_CYC = us_to_cyc(T_POWERUP_US, CLK_PERIOD_NS);
    localparam int CNT_W  = $clog2(T_POWERUP_CYC + T_RP_CYC + T_RFC_CYC + T_MRD_CYC + 1);
    localparam int ACNT_W = $clog2(INIT_AREF_NUM + 1);

    localparam logic [2:0]        CAS_CODE = 3'(CAS_LAT);
    localparam logic [ADDR_W-1:0] PRE_ADDR = ADDR_W'(11'h400);
    localparam logic [ADDR_W-1:0] MRS_ADDR = ADDR_W'({CAS_CODE, 1'b0, bl_code(BURST_LEN)});

    if (!(CAS_LAT == 2 || CAS_LAT == 3)) begin : g_bad_cas
        $fatal(1, "sdram_init_aref: CAS_LAT must be 2 or 3");
    end
    if (!bl_legal(BURST_LEN)) begin : g_bad_bl
        $fatal(1, "sdram_init_aref: BURST_LEN must be 0, 1, 2, 4 or 8");
    end
    if (ADDR_W < 11) begin : g_bad_addr
        $fatal(1, "sdram_init_aref: ADDR_W must be at least 11");
    end

    aref_state_e        state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [ACNT_W-1:0]  aref_cnt, aref_cnt_nxt;
    logic [3:0]         cmd_nxt;
    logic [ADDR_W-1:0]  addr_nxt;
    logic               init_done_nxt;
    logic               aref_done_nxt;
    logic               req_clr;

    // Refresh interval timer runs only once init has finished.
    sdram_aref_timer #(
        .T_REFI_CYC (T_REFI_CYC)
    ) u_timer (
        .sclk      (sclk),
        .s_rst_n   (s_rst_n),
        .enable    (init_done),
        .req_clr   (req_clr),
        .aref_req  (aref_req),
        .aref_miss (aref_miss)
    );

    // State, wait counter and registered command bus.
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state      <= ST_PWR;
            cnt        <= CNT_W'(T_POWERUP_CYC);
            aref_cnt   <= '0;
            sdram_cke  <= 1'b0;
            sdram_cmd  <= CMD_NOP;
            sdram_addr <= '0;
            sdram_bank <= '0;
            init_done  <= 1'b0;
            aref_done  <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            aref_cnt   <= aref_cnt_nxt;
            sdram_cke  <= 1'b1;
            sdram_cmd  <= cmd_nxt;
            sdram_addr <= addr_nxt;
            sdram_bank <= '0;
            init_done  <= init_done_nxt;
            aref_done  <= aref_done_nxt;
        end
    end

    // Next-state, command selection and wait-counter reloads.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = (cnt == '0) ? cnt : cnt - 1'b1;
        aref_cnt_nxt  = aref_cnt;
        cmd_nxt       = CMD_NOP;
        addr_nxt      = '0;
        init_done_nxt = init_done;
        aref_done_nxt = 1'b0;
        req_clr       = 1'b0;
        case (state)
            ST_PWR: begin
                if (cnt == '0) begin
                    cmd_nxt   = CMD_PRE;
                    addr_nxt  = PRE_ADDR;
                    cnt_nxt   = CNT_W'(T_RP_CYC - 1);
                    state_nxt = ST_TRP;
                end
            end
            ST_TRP: begin
                if (cnt == '0) begin
                    cmd_nxt      = CMD_AREF;
                    aref_cnt_nxt = aref_cnt + 1'b1;
                    cnt_nxt      = CNT_W'(T_RFC_CYC - 1);
                    state_nxt    = ST_TRFC;
                end
            end
            ST_TRFC: begin
                if (cnt == '0) begin
                    if (aref_cnt < ACNT_W'(INIT_AREF_NUM)) begin
                        cmd_nxt      = CMD_AREF;
                        aref_cnt_nxt = aref_cnt + 1'b1;
                        cnt_nxt      = CNT_W'(T_RFC_CYC - 1);
                    end else begin
                        cmd_nxt   = CMD_MRS;
                        addr_nxt  = MRS_ADDR;
                        cnt_nxt   = CNT_W'(T_MRD_CYC - 1);
                        state_nxt = ST_TMRD;
                    end
                end
            end
            ST_TMRD: begin
                if (cnt == '0) begin
                    init_done_nxt = 1'b1;
                    state_nxt     = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (aref_req && aref_en) begin
                    cmd_nxt   = CMD_PRE;
                    addr_nxt  = PRE_ADDR;
                    req_clr   = 1'b1;
                    cnt_nxt   = CNT_W'(T_RP_CYC - 1);
                    state_nxt = ST_RTRP;
                end
            end
            ST_RTRP: begin
                if (cnt == '0) begin
                    cmd_nxt   = CMD_AREF;
                    cnt_nxt   = CNT_W'(T_RFC_CYC - 1);
                    state_nxt = ST_RTRFC;
                end
            end
            ST_RTRFC: begin
                if (cnt == '0) begin
                    aref_done_nxt = 1'b1;
                    state_nxt     = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_PWR;
            end
        endcase
    end

endmodule

// File: tb/tb_sdram_init_aref.sv
// Bench for sdram_init_aref: command-bus scoreboard plus cycle spot-check tables.
module tb_sdram_init_aref;
    import sdram_pkg::*;

    typedef struct {
        int         cyc;
        logic [3:0] cmd;
        logic [12:0] addr;
    } ev_t;

    typedef struct {
        int   cyc;
        logic cke;
        logic init;
        logic req;
        logic done;
        logic miss;
        logic init2;
        logic en;
    } vec_t;

    localparam logic [23:0] RST_VEC = {1'b0, 4'b0111, 19'd0};

    logic        sclk;
    logic        s_rst_n;
    logic        rst2_n;
    logic        aref_en;
    logic        aref_en2;

    logic        d1_cke, d1_init, d1_req, d1_done, d1_miss;
    logic [3:0]  d1_cmd;
    logic [12:0] d1_addr;
    logic [1:0]  d1_bank;
    logic        d2_cke, d2_init, d2_req, d2_done, d2_miss;
    logic [3:0]  d2_cmd;
    logic [12:0] d2_addr;
    logic [1:0]  d2_bank;

    int cyc;
    int cyc2;
    int errors;
    int checks;
    ev_t q1[$];
    ev_t q2[$];
    int  dq[$];
    vec_t va[13];
    vec_t vb[16];

    sdram_init_aref u_dut (
        .sclk       (sclk),
        .s_rst_n    (s_rst_n),
        .sdram_cke  (d1_cke),
        .sdram_cmd  (d1_cmd),
        .sdram_addr (d1_addr),
        .sdram_bank (d1_bank),
        .init_done  (d1_init),
        .aref_req   (d1_req),
        .aref_en    (aref_en),
        .aref_done  (d1_done),
        .aref_miss  (d1_miss)
    );

    sdram_init_aref #(
        .CAS_LAT       (2),
        .BURST_LEN     (0),
        .INIT_AREF_NUM (2)
    ) u_dut2 (
        .sclk       (sclk),
        .s_rst_n    (rst2_n),
        .sdram_cke  (d2_cke),
        .sdram_cmd  (d2_cmd),
        .sdram_addr (d2_addr),
        .sdram_bank (d2_bank),
        .init_done  (d2_init),
        .aref_req   (d2_req),
        .aref_en    (aref_en2),
        .aref_done  (d2_done),
        .aref_miss  (d2_miss)
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    // Cycle index of the most recent rising edge since reset release.
    always @(posedge sclk) begin
        cyc  <= s_rst_n ? cyc + 1 : -1;
        cyc2 <= rst2_n ? cyc2 + 1 : -1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %0h want %0h", name, cyc, act, exp);
        end
    endtask

    // Scoreboard for the main instance: every non-NOP command and every done pulse.
    always @(negedge sclk) begin
        if (s_rst_n && cyc >= 0) begin
            if (d1_cmd != CMD_NOP) begin
                if (q1.size() == 0) begin
                    check("unexpected_cmd", 32'(d1_cmd), 32'(CMD_NOP));
                end else begin
                    ev_t e;
                    e = q1.pop_front();
                    check("cmd_cycle", cyc, e.cyc);
                    check("cmd_code", 32'(d1_cmd), 32'(e.cmd));
                    check("cmd_addr", 32'(d1_addr), 32'(e.addr));
                    check("cmd_bank", 32'(d1_bank), 32'd0);
                end
            end
            if (d1_done) begin
                if (dq.size() == 0) begin
                    check("unexpected_done", 32'(d1_done), 32'd0);
                end else begin
                    check("done_cycle", cyc, dq.pop_front());
                end
            end
        end
    end

    // Scoreboard for the CAS2 / full-page / 2-refresh instance.
    always @(negedge sclk) begin
        if (rst2_n && cyc2 >= 0) begin
            if (d2_cmd != CMD_NOP) begin
                if (q2.size() == 0) begin
                    check("d2_unexpected_cmd", 32'(d2_cmd), 32'(CMD_NOP));
                end else begin
                    ev_t e;
                    e = q2.pop_front();
                    check("d2_cmd_cycle", cyc2, e.cyc);
                    check("d2_cmd_code", 32'(d2_cmd), 32'(e.cmd));
                    check("d2_cmd_addr", 32'(d2_addr), 32'(e.addr));
                end
            end
            if (d2_done) check("d2_done", 32'(d2_done), 32'd0);
        end
    end

    task automatic push1(input int c, input logic [3:0] cmd, input logic [12:0] a);
        ev_t e;
        e.cyc  = c;
        e.cmd  = cmd;
        e.addr = a;
        q1.push_back(e);
    endtask

    task automatic push2(input int c, input logic [3:0] cmd, input logic [12:0] a);
        ev_t e;
        e.cyc  = c;
        e.cmd  = cmd;
        e.addr = a;
        q2.push_back(e);
    endtask

    task automatic push_init1();
        push1(10000, CMD_PRE, 13'h400);
        for (int k = 0; k < 8; k++) push1(10002 + 7 * k, CMD_AREF, 13'h000);
        push1(10058, CMD_MRS, 13'h032);
    endtask

    task automatic wait_cyc(input int target);
        int guard;
        guard = 0;
        while (cyc < target && guard < 20000) begin
            @(negedge sclk);
            guard++;
        end
        if (cyc != target) check("wait_budget", cyc, target);
    endtask

    task automatic run_vec(input vec_t v, input bit chk2);
        wait_cyc(v.cyc);
        check("cke", 32'(d1_cke), 32'(v.cke));
        check("init_done", 32'(d1_init), 32'(v.init));
        check("aref_req", 32'(d1_req), 32'(v.req));
        check("aref_done", 32'(d1_done), 32'(v.done));
        check("aref_miss", 32'(d1_miss), 32'(v.miss));
        if (chk2) check("d2_init_done", 32'(d2_init), 32'(v.init2));
        aref_en = v.en;
    endtask

    initial begin
        errors   = 0;
        checks   = 0;
        s_rst_n  = 1'b0;
        rst2_n   = 1'b0;
        aref_en  = 1'b1;
        aref_en2 = 1'b0;

        //          cyc    cke init req done miss init2 en
        va[0]  = '{0,     1, 0, 0, 0, 0, 0, 1};
        va[1]  = '{10017, 1, 0, 0, 0, 0, 0, 1};
        va[2]  = '{10018, 1, 0, 0, 0, 0, 1, 1};
        va[3]  = '{10059, 1, 0, 0, 0, 0, 1, 1};
        va[4]  = '{10060, 1, 1, 0, 0, 0, 1, 1};
        va[5]  = '{10449, 1, 1, 0, 0, 0, 1, 1};
        va[6]  = '{10450, 1, 1, 1, 0, 0, 1, 1};
        va[7]  = '{10451, 1, 1, 0, 0, 0, 1, 1};
        va[8]  = '{10460, 1, 1, 0, 1, 0, 1, 1};
        va[9]  = '{10461, 1, 1, 0, 0, 0, 1, 1};
        va[10] = '{10840, 1, 1, 1, 0, 0, 1, 1};
        va[11] = '{10841, 1, 1, 0, 0, 0, 1, 1};
        va[12] = '{10850, 1, 1, 0, 1, 0, 1, 1};

        vb[0]  = '{10005, 1, 0, 0, 0, 0, 0, 1};
        vb[1]  = '{10008, 1, 0, 0, 0, 0, 0, 0};
        vb[2]  = '{10060, 1, 1, 0, 0, 0, 0, 0};
        vb[3]  = '{10100, 1, 1, 0, 0, 0, 0, 1};
        vb[4]  = '{10105, 1, 1, 0, 0, 0, 0, 0};
        vb[5]  = '{10110, 1, 1, 0, 0, 0, 0, 0};
        vb[6]  = '{10449, 1, 1, 0, 0, 0, 0, 0};
        vb[7]  = '{10450, 1, 1, 1, 0, 0, 0, 0};
        vb[8]  = '{10839, 1, 1, 1, 0, 0, 0, 0};
        vb[9]  = '{10840, 1, 1, 1, 0, 1, 0, 0};
        vb[10] = '{10900, 1, 1, 1, 0, 1, 0, 1};
        vb[11] = '{10901, 1, 1, 0, 0, 1, 0, 1};
        vb[12] = '{10910, 1, 1, 0, 1, 1, 0, 1};
        vb[13] = '{10950, 1, 1, 0, 0, 1, 0, 0};
        vb[14] = '{11229, 1, 1, 0, 0, 1, 0, 0};
        vb[15] = '{11230, 1, 1, 1, 0, 1, 0, 0};

        // Phase A: defaults with grant tied high, plus the alternate-parameter instance.
        repeat (3) @(negedge sclk);
        check("rst_vals", 32'({d1_cke, d1_cmd, d1_addr, d1_bank, d1_init, d1_req, d1_done, d1_miss}), 32'(RST_VEC));
        check("d2_rst_vals", 32'({d2_cke, d2_cmd, d2_addr, d2_bank, d2_init, d2_req, d2_done, d2_miss}), 32'(RST_VEC));
        push_init1();
        push1(10451, CMD_PRE, 13'h400);
        push1(10453, CMD_AREF, 13'h000);
        push1(10841, CMD_PRE, 13'h400);
        push1(10843, CMD_AREF, 13'h000);
        dq.push_back(10460);
        dq.push_back(10850);
        push2(10000, CMD_PRE, 13'h400);
        push2(10002, CMD_AREF, 13'h000);
        push2(10009, CMD_AREF, 13'h000);
        push2(10016, CMD_MRS, 13'h027);
        s_rst_n = 1'b1;
        rst2_n  = 1'b1;
        for (int i = 0; i < 13; i++) run_vec(va[i], 1'b1);
        wait_cyc(10870);
        check("a_cmd_left", 32'(q1.size()), 32'd0);
        check("a_done_left", 32'(dq.size()), 32'd0);
        check("d2_cmd_left", 32'(q2.size()), 32'd0);

        // Phase B1: fresh init interrupted by reset in the middle of the refresh run.
        #2;
        s_rst_n = 1'b0;
        rst2_n  = 1'b0;
        aref_en = 1'b0;
        q1.delete();
        dq.delete();
        push1(10000, CMD_PRE, 13'h400);
        for (int k = 0; k < 5; k++) push1(10002 + 7 * k, CMD_AREF, 13'h000);
        repeat (3) @(negedge sclk);
        s_rst_n = 1'b1;
        wait_cyc(10030);
        #2;
        s_rst_n = 1'b0;
        #1;
        check("async_rst_vals", 32'({d1_cke, d1_cmd, d1_addr, d1_bank, d1_init, d1_req, d1_done, d1_miss}), 32'(RST_VEC));
        check("b1_cmd_left", 32'(q1.size()), 32'd0);

        // Phase B2: re-init from scratch, ignored grants, missed interval, late grant.
        repeat (3) @(negedge sclk);
        push_init1();
        push1(10901, CMD_PRE, 13'h400);
        push1(10903, CMD_AREF, 13'h000);
        dq.push_back(10910);
        s_rst_n = 1'b1;
        for (int i = 0; i < 16; i++) run_vec(vb[i], 1'b0);
        wait_cyc(11240);
        check("b2_cmd_left", 32'(q1.size()), 32'd0);
        check("b2_done_left", 32'(dq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
